// File: rtl/spike_aer_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : spike_aer_encoder                                          |
// | Description : Collects single-cycle spike pulses from a neuron array and |
// |               serialises them into address-events (neuron index plus     |
// |               time-step stamp) on a valid/ready stream. Round-robin      |
// |               arbitration, one pending spike per neuron, drop reporting. |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module spike_aer_encoder #(
  parameter int N_NEURONS = 10,
  parameter int ADDR_W    = 4,
  parameter int TS_W      = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [N_NEURONS-1:0] spike_in_i,
  input  logic                 tick_i,
  input  logic                 ev_ready_i,
  output logic                 ev_valid_o,
  output logic [ADDR_W-1:0]    ev_addr_o,
  output logic [TS_W-1:0]      ev_ts_o,
  input  logic                 clr_ovf_i,
  output logic                 overflow_o,
  output logic [7:0]           drop_cnt_o
);

  // Width of the per-cycle drop count (0..N_NEURONS).
  localparam int c_CNT_W = $clog2(N_NEURONS + 1);

  // Registered state
  logic [N_NEURONS-1:0] pend_q;
  logic [N_NEURONS-1:0] pend_d;
  logic [ADDR_W-1:0]    ptr_q;
  logic [ADDR_W-1:0]    ptr_d;
  logic [TS_W-1:0]      ts_q;
  logic                 ev_valid_q;
  logic [ADDR_W-1:0]    ev_addr_q;
  logic [TS_W-1:0]      ev_ts_q;
  logic                 ovf_q;
  logic                 ovf_d;
  logic [7:0]           drop_cnt_q;
  logic [7:0]           drop_cnt_d;

  // Combinational arbitration / drop signals
  logic [N_NEURONS-1:0] w_mask;
  logic [N_NEURONS-1:0] w_hi;
  logic                 w_hi_found;
  logic [ADDR_W-1:0]    w_hi_idx;
  logic                 w_any_found;
  logic [ADDR_W-1:0]    w_lo_idx;
  logic [ADDR_W-1:0]    w_sel;
  logic                 w_slot_free;
  logic                 w_grant_en;
  logic [N_NEURONS-1:0] w_grant;
  logic [N_NEURONS-1:0] w_drop;
  logic [c_CNT_W-1:0]   w_drop_num;
  logic [7:0]           w_cnt_base;
  logic [8:0]           w_cnt_sum;

  // The slot can take a new event when it is empty or being emptied this cycle.
  assign w_slot_free = ~ev_valid_q | ev_ready_i;

  // Per-neuron mask of positions at or above the priority pointer, grant
  // decode, drop detection and pending-bit update.
  for (genvar i = 0; i < N_NEURONS; i++) begin : g_bit
    assign w_mask[i]  = (ADDR_W'(i) >= ptr_q);
    assign w_grant[i] = w_grant_en & (w_sel == ADDR_W'(i));
    // A spike landing on a still-pending bit that is not leaving this cycle
    // merges into it and is counted as lost.
    assign w_drop[i]  = spike_in_i[i] & pend_q[i] & ~w_grant[i];
    assign pend_d[i]  = spike_in_i[i] | (pend_q[i] & ~w_grant[i]);
  end

  assign w_hi = pend_q & w_mask;

  // Round-robin search: lowest pending index at/above the pointer, otherwise
  // wrap around to the lowest pending index overall.
  always_comb begin
    w_hi_found  = 1'b0;
    w_hi_idx    = '0;
    w_any_found = 1'b0;
    w_lo_idx    = '0;
    // Descending scan so that the lowest set index is the last one written.
    for (int k = N_NEURONS - 1; k >= 0; k--) begin
      if (w_hi[k]) begin
        w_hi_found = 1'b1;
        w_hi_idx   = ADDR_W'(k);
      end
      if (pend_q[k]) begin
        w_any_found = 1'b1;
        w_lo_idx    = ADDR_W'(k);
      end
    end
  end

  assign w_sel      = w_hi_found ? w_hi_idx : w_lo_idx;
  assign w_grant_en = w_slot_free & w_any_found;

  // Next pointer sits just past the granted index, wrapping at the array end.
  assign ptr_d = (w_sel == ADDR_W'(N_NEURONS - 1)) ? '0 : (w_sel + 1'b1);

  // Count how many neurons lost a spike this cycle.
  always_comb begin
    w_drop_num = '0;
    for (int i = 0; i < N_NEURONS; i++) begin
      w_drop_num = w_drop_num + c_CNT_W'(w_drop[i]);
    end
  end

  // Drop statistics: a clear and a simultaneous drop leave only this
  // cycle's drops in the counter; the counter saturates at 255.
  always_comb begin
    w_cnt_base = clr_ovf_i ? 8'd0 : drop_cnt_q;
    w_cnt_sum  = {1'b0, w_cnt_base} + 9'(w_drop_num);
    ovf_d      = (ovf_q & ~clr_ovf_i) | (|w_drop);
    if (|w_drop) begin
      drop_cnt_d = w_cnt_sum[8] ? 8'hFF : w_cnt_sum[7:0];
    end else begin
      drop_cnt_d = w_cnt_base;
    end
  end

  // State update: pending bits, output slot, pointer, timestamp and drop stats.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q     <= '0;
      ptr_q      <= '0;
      ts_q       <= '0;
      ev_valid_q <= 1'b0;
      ev_addr_q  <= '0;
      ev_ts_q    <= '0;
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      pend_q <= pend_d;
      if (w_grant_en) begin
        // Stamp uses the timestamp before any coincident tick.
        ev_valid_q <= 1'b1;
        ev_addr_q  <= w_sel;
        ev_ts_q    <= ts_q;
        ptr_q      <= ptr_d;
      end else if (w_slot_free) begin
        ev_valid_q <= 1'b0;
      end
      if (tick_i) begin
        ts_q <= ts_q + 1'b1;
      end
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign ev_valid_o = ev_valid_q;
  assign ev_addr_o  = ev_addr_q;
  assign ev_ts_o    = ev_ts_q;
  assign overflow_o = ovf_q;
  assign drop_cnt_o = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_spike_aer_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_spike_aer_encoder                                       |
// | Description : Directed self-checking bench for spike_aer_encoder with a  |
// |               behavioural reference model and literal expectations.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_spike_aer_encoder;

  localparam int N  = 10;
  localparam int AW = 4;
  localparam int TW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  spike;
  logic          tick;
  logic          ready;
  logic          clr;
  logic          ev_valid;
  logic [AW-1:0] ev_addr;
  logic [TW-1:0] ev_ts;
  logic          overflow;
  logic [7:0]    drop_cnt;

  always #5 clk = ~clk;

  spike_aer_encoder #(
    .N_NEURONS(N),
    .ADDR_W   (AW),
    .TS_W     (TW)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .spike_in_i(spike),
    .tick_i    (tick),
    .ev_ready_i(ready),
    .ev_valid_o(ev_valid),
    .ev_addr_o (ev_addr),
    .ev_ts_o   (ev_ts),
    .clr_ovf_i (clr),
    .overflow_o(overflow),
    .drop_cnt_o(drop_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference model: list of pending neurons, pointer, timestamp, slot.
  bit m_pend[N];
  int m_ptr, m_ts, m_valid, m_addr, m_evts, m_ovf, m_cnt;
  int cyc = 0;
  bit started = 0;

  typedef struct {
    int addr;
    int ts;
    int cyc;
  } ev_t;
  ev_t evq[$];

  // Model step on each rising edge using the inputs held stable since the last edge.
  initial begin
    forever begin
      int g, nd;
      bit free;
      @(posedge clk);
      if (rst) begin
        for (int i = 0; i < N; i++) m_pend[i] = 0;
        m_ptr = 0; m_ts = 0; m_valid = 0; m_addr = 0; m_evts = 0; m_ovf = 0; m_cnt = 0;
      end else begin
        free = (m_valid == 0) || ready;
        g = -1;
        if (free) begin
          for (int k = 0; k < N; k++) begin
            if (g < 0 && m_pend[(m_ptr + k) % N]) g = (m_ptr + k) % N;
          end
        end
        nd = 0;
        for (int i = 0; i < N; i++) begin
          if (spike[i] && m_pend[i] && i != g) nd++;
        end
        if (free) begin
          if (g >= 0) begin
            m_valid = 1; m_addr = g; m_evts = m_ts; m_ptr = (g + 1) % N;
          end else begin
            m_valid = 0;
          end
        end
        for (int i = 0; i < N; i++) begin
          if (i == g) m_pend[i] = 0;
          if (spike[i]) m_pend[i] = 1;
        end
        if (clr) begin
          m_cnt = 0; m_ovf = 0;
        end
        if (nd > 0) begin
          m_ovf = 1;
          m_cnt = (m_cnt + nd > 255) ? 255 : m_cnt + nd;
        end
        if (tick) m_ts = (m_ts + 1) % 65536;
      end
      started = 1;
      cyc++;
    end
  end

  // Compare process: checks every cycle on the falling edge and logs transfers.
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        chk("ev_valid", 32'(ev_valid), 32'(m_valid));
        if (m_valid != 0) begin
          chk("ev_addr", 32'(ev_addr), 32'(m_addr));
          chk("ev_ts", 32'(ev_ts), 32'(m_evts));
        end
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("drop_cnt", 32'(drop_cnt), 32'(m_cnt));
        if (ev_valid && ready && !rst) begin
          evq.push_back('{addr: int'(ev_addr), ts: int'(ev_ts), cyc: cyc});
        end
      end
    end
  end

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    evq.delete();
  endtask

  task automatic rr_burst(input string tag);
    evq.delete();
    spike = 10'h3FF;
    run(1);
    spike = '0;
    run(12);
    chk({tag, "_count"}, 32'(evq.size()), 32'd10);
    for (int i = 0; i < 10 && i < evq.size(); i++) begin
      chk({tag, "_addr"}, 32'(evq[i].addr), 32'(i));
      chk({tag, "_consec"}, 32'(evq[i].cyc - evq[0].cyc), 32'(i));
    end
  endtask

  initial begin
    rst = 1'b1; spike = '1; tick = 1'b0; ready = 1'b1; clr = 1'b0;

    // Reset with all spikes asserted: nothing may survive.
    run(3);
    rst = 1'b0;
    spike = '0;
    evq.delete();
    chk("rst_valid", 32'(ev_valid), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    run(5);
    chk("rst_no_events", 32'(evq.size()), 32'd0);

    // Single spike on neuron 2 at TS=5.
    tick = 1'b1;
    run(5);
    tick = 1'b0;
    spike = 10'h004;
    run(1);
    spike = '0;
    chk("single_lat1_valid", 32'(ev_valid), 32'd0);
    run(1);
    chk("single_valid", 32'(ev_valid), 32'd1);
    chk("single_addr", 32'(ev_addr), 32'd2);
    chk("single_ts", 32'(ev_ts), 32'd5);
    run(1);
    chk("single_after_valid", 32'(ev_valid), 32'd0);
    run(3);
    chk("single_count", 32'(evq.size()), 32'd1);

    // Round robin from pointer 0, twice.
    do_reset();
    rr_burst("rr1");
    rr_burst("rr2");

    // Backpressure: event on address 3 held for 20 cycles, then one transfer.
    evq.delete();
    ready = 1'b0;
    spike = 10'h008;
    run(1);
    spike = '0;
    run(20);
    chk("bp_valid", 32'(ev_valid), 32'd1);
    chk("bp_addr", 32'(ev_addr), 32'd3);
    chk("bp_ts", 32'(ev_ts), 32'd0);
    ready = 1'b1;
    run(5);
    chk("bp_once", 32'(evq.size()), 32'd1);
    if (evq.size() > 0) chk("bp_xfer_addr", 32'(evq[0].addr), 32'd3);

    // Drops: neuron 0 parks in the slot, neuron 7 pulsed three times.
    ready = 1'b0;
    spike = 10'h001;
    run(1);
    spike = '0;
    run(2);
    for (int p = 0; p < 3; p++) begin
      spike = 10'h080;
      run(1);
      spike = '0;
      run(1);
    end
    chk("drop_cnt2", 32'(drop_cnt), 32'd2);
    chk("drop_ovf", 32'(overflow), 32'd1);
    clr = 1'b1;
    run(1);
    clr = 1'b0;
    chk("clr_cnt", 32'(drop_cnt), 32'd0);
    chk("clr_ovf", 32'(overflow), 32'd0);
    spike = 10'h080;
    run(300);
    spike = '0;
    chk("sat_cnt", 32'(drop_cnt), 32'd255);
    chk("sat_ovf", 32'(overflow), 32'd1);
    spike = 10'h080;
    clr = 1'b1;
    run(1);
    spike = '0;
    clr = 1'b0;
    chk("clr_vs_drop_cnt", 32'(drop_cnt), 32'd1);
    chk("clr_vs_drop_ovf", 32'(overflow), 32'd1);
    ready = 1'b1;
    run(5);

    // Coincidence: grant at TS=0xFFFF with a tick, and a re-spike in the grant cycle.
    do_reset();
    tick = 1'b1;
    run(65535);
    tick = 1'b0;
    spike = 10'h002;
    run(1);
    spike = 10'h002;
    tick = 1'b1;
    run(1);
    spike = '0;
    tick = 1'b0;
    run(4);
    chk("coin_count", 32'(evq.size()), 32'd2);
    if (evq.size() >= 2) begin
      chk("coin_addr0", 32'(evq[0].addr), 32'd1);
      chk("coin_ts0", 32'(evq[0].ts), 32'hFFFF);
      chk("coin_addr1", 32'(evq[1].addr), 32'd1);
      chk("coin_ts1", 32'(evq[1].ts), 32'd0);
    end
    chk("coin_drop", 32'(drop_cnt), 32'd0);
    chk("coin_ovf", 32'(overflow), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
